// File: rtl/jpeg_packer_pkg.sv
// Shared constants and helpers for the JPEG byte packer.
package jpeg_packer_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned STRB_W         = BYTES_PER_WORD;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI           = 8'hD9;

  // Contiguous lane mask for n valid bytes (n = 1..4); zero otherwise.
  function automatic logic [STRB_W-1:0] strb_from_count(input logic [2:0] n);
    logic [STRB_W-1:0] m;
    case (n)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      3'd4:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/jpeg_packer_out_slot.sv
// One-entry holding register for packed words toward the decoder inport.
module jpeg_packer_out_slot
  import jpeg_packer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic [STRB_W-1:0] push_strb,
  input  logic              push_last,
  input  logic              accept,
  output logic              valid,
  output logic [WORD_W-1:0] data,
  output logic [STRB_W-1:0] strb,
  output logic              last,
  output logic              slot_free_c
);

  assign slot_free_c = ~valid | accept;

  // Producer only pushes when slot_free_c is high, so a push always wins.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= 1'b0;
      data  <= '0;
      strb  <= '0;
      last  <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
      strb  <= push_strb;
      last  <= push_last;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/jpeg_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words with strobes and last.
// Optional EOI (FF D9) forced flush: define JPEG_PACKER_EOI_DETECT_EN.
module jpeg_byte_packer
  import jpeg_packer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_last_i,
  output logic              byte_ready_o,
  output logic              outport_valid_o,
  output logic [WORD_W-1:0] outport_data_o,
  output logic [STRB_W-1:0] outport_strb_o,
  output logic              outport_last_o,
  input  logic              outport_accept_i,
  output logic [CNT_W-1:0]  byte_count_o,
  output logic              idle_o
);

  logic [WORD_W-1:0] acc_data_q, acc_data_d;
  logic [2:0]        acc_cnt_q, acc_cnt_d;
  logic              acc_last_q, acc_last_d;
  logic [CNT_W-1:0]  byte_count_q;

  logic              slot_free_c;
  logic              byte_fire_c;
  logic              eff_last_c;
  logic              complete_c;
  logic              push_c;
  logic [WORD_W-1:0] lane_word_c;
  logic [WORD_W-1:0] push_data_c;
  logic [STRB_W-1:0] push_strb_c;
  logic              push_last_c;

  assign byte_ready_o = ~acc_last_q & (slot_free_c | (acc_cnt_q < 3'd3));
  assign byte_fire_c  = byte_valid_i & byte_ready_o;
  assign lane_word_c  = acc_data_q | (WORD_W'(byte_data_i) << {acc_cnt_q[1:0], 3'b000});
  assign complete_c   = byte_fire_c & ((acc_cnt_q == 3'(BYTES_PER_WORD - 1)) | eff_last_c);

`ifdef JPEG_PACKER_EOI_DETECT_EN
  logic ff_seen_q;

  assign eff_last_c = byte_last_i | (ff_seen_q & (byte_data_i == JPEG_EOI));

  // Tracks whether the previous accepted byte was a marker prefix.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ff_seen_q <= 1'b0;
    end else if (byte_fire_c) begin
      ff_seen_q <= (byte_data_i == JPEG_MARKER_PREFIX) & ~eff_last_c;
    end
  end
`else
  assign eff_last_c = byte_last_i;
`endif

  // Word push and accumulator next-state; a parked last word drains first.
  always_comb begin
    push_c      = 1'b0;
    push_data_c = lane_word_c;
    push_strb_c = strb_from_count(acc_cnt_q + 3'd1);
    push_last_c = eff_last_c;
    acc_data_d  = acc_data_q;
    acc_cnt_d   = acc_cnt_q;
    acc_last_d  = acc_last_q;
    if (acc_last_q) begin
      push_data_c = acc_data_q;
      push_strb_c = strb_from_count(acc_cnt_q);
      push_last_c = 1'b1;
      if (slot_free_c) begin
        push_c     = 1'b1;
        acc_data_d = '0;
        acc_cnt_d  = 3'd0;
        acc_last_d = 1'b0;
      end
    end else if (complete_c && slot_free_c) begin
      push_c     = 1'b1;
      acc_data_d = '0;
      acc_cnt_d  = 3'd0;
    end else if (byte_fire_c) begin
      acc_data_d = lane_word_c;
      acc_cnt_d  = acc_cnt_q + 3'd1;
      acc_last_d = complete_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_data_q   <= '0;
      acc_cnt_q    <= 3'd0;
      acc_last_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      acc_data_q <= acc_data_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_last_q <= acc_last_d;
      if (byte_fire_c) begin
        byte_count_q <= byte_count_q + CNT_W'(1);
      end
    end
  end

  jpeg_packer_out_slot u_out_slot (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push        (push_c),
    .push_data   (push_data_c),
    .push_strb   (push_strb_c),
    .push_last   (push_last_c),
    .accept      (outport_accept_i),
    .valid       (outport_valid_o),
    .data        (outport_data_o),
    .strb        (outport_strb_o),
    .last        (outport_last_o),
    .slot_free_c (slot_free_c)
  );

  assign byte_count_o = byte_count_q;
  assign idle_o       = (acc_cnt_q == 3'd0) & ~acc_last_q & ~outport_valid_o;

endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Scoreboard bench for jpeg_byte_packer: a byte-level model predicts every word.
module tb_jpeg_byte_packer;

  localparam int unsigned CNT_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             byte_valid_i = 1'b0;
  logic [7:0]       byte_data_i = 8'h00;
  logic             byte_last_i = 1'b0;
  logic             byte_ready_o;
  logic             outport_valid_o;
  logic [31:0]      outport_data_o;
  logic [3:0]       outport_strb_o;
  logic             outport_last_o;
  logic             outport_accept_i = 1'b1;
  logic [CNT_W-1:0] byte_count_o;
  logic             idle_o;

  int errors = 0;
  int checks = 0;

  logic [36:0] exp_q[$];
  logic [31:0] m_data = '0;
  int          m_cnt = 0;
  bit          m_ff = 1'b0;
  bit          hold_pending = 1'b0;
  logic [37:0] hold_word = '0;

  jpeg_byte_packer #(.CNT_W(CNT_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .byte_valid_i     (byte_valid_i),
    .byte_data_i      (byte_data_i),
    .byte_last_i      (byte_last_i),
    .byte_ready_o     (byte_ready_o),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_strb_o   (outport_strb_o),
    .outport_last_o   (outport_last_o),
    .outport_accept_i (outport_accept_i),
    .byte_count_o     (byte_count_o),
    .idle_o           (idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mask_of(input int n);
    case (n)
      1: return 4'h1;
      2: return 4'h3;
      3: return 4'h7;
      4: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  // Monitor: byte model builds expected words; output words are popped and compared.
  always @(negedge clk_i) begin
    logic eff;
    if (!rst_i) begin
      exp_q.delete();
      m_data = '0;
      m_cnt = 0;
      m_ff = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        chk("hold", 64'({outport_valid_o, outport_last_o, outport_strb_o, outport_data_o}),
            64'(hold_word));
      hold_pending = outport_valid_o & ~outport_accept_i;
      hold_word = {1'b1, outport_last_o, outport_strb_o, outport_data_o};
      if (outport_valid_o && outport_accept_i) begin
        if (exp_q.size() == 0) chk("unexpected_word", 64'(outport_data_o), 64'hDEAD_0000);
        else chk("word", 64'({outport_last_o, outport_strb_o, outport_data_o}),
                 64'(exp_q.pop_front()));
      end
      if (byte_valid_i && byte_ready_o) begin
        eff = byte_last_i;
`ifdef JPEG_PACKER_EOI_DETECT_EN
        if (m_ff && byte_data_i == 8'hD9) eff = 1'b1;
        m_ff = (byte_data_i == 8'hFF) && !eff;
`endif
        m_data[8*m_cnt +: 8] = byte_data_i;
        m_cnt++;
        if (m_cnt == 4 || eff) begin
          exp_q.push_back({eff, mask_of(m_cnt), m_data});
          m_cnt = 0;
          m_data = '0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte fires.
  task automatic send(input logic [7:0] b, input logic l);
    bit done = 1'b0;
    byte_valid_i = 1'b1;
    byte_data_i = b;
    byte_last_i = l;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      done = byte_ready_o;
      @(posedge clk_i);
      #1;
    end
    byte_valid_i = 1'b0;
    byte_last_i = 1'b0;
    if (!done) chk("byte_timeout", 64'(done), 64'd1);
  endtask

  task automatic send_seq(input logic [7:0] first, input int n, input logic last_at_end);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      send(b, last_at_end && (i == n - 1));
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk_i);
      done = (exp_q.size() == 0) && idle_o;
    end
    if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(outport_valid_o), 64'd0);
    chk({tag, "_data"},  64'(outport_data_o),  64'd0);
    chk({tag, "_strb"},  64'(outport_strb_o),  64'd0);
    chk({tag, "_last"},  64'(outport_last_o),  64'd0);
    chk({tag, "_count"}, 64'(byte_count_o),    64'd0);
    chk({tag, "_idle"},  64'(idle_o),          64'd1);
  endtask

  initial begin
    #12;
    check_reset_outputs("rst");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("ready_after_rst", 64'(byte_ready_o), 64'd1);

    // Full words then a full last word.
    send_seq(8'h01, 8, 1'b1);
    drain();
    chk("count_8", 64'(byte_count_o), 64'd8);
    chk("idle_8", 64'(idle_o), 64'd1);

    // 1-, 2-, 3-byte tails.
    send_seq(8'h11, 5, 1'b1);
    send_seq(8'h21, 6, 1'b1);
    send_seq(8'h31, 7, 1'b1);
    drain();
    chk("count_26", 64'(byte_count_o), 64'd26);

    // Backpressure: one word held, three bytes buffered, ready drops.
    outport_accept_i = 1'b0;
    fork
      send_seq(8'hC0, 9, 1'b1);
      begin
        repeat (10) @(negedge clk_i);
        chk("bp_ready", 64'(byte_ready_o), 64'd0);
        chk("bp_count", 64'(byte_count_o), 64'd33);
        chk("bp_valid", 64'(outport_valid_o), 64'd1);
        @(posedge clk_i);
        #1;
        outport_accept_i = 1'b1;
      end
    join
    drain();

    // Last byte at lane 1 with the slot stalled.
    outport_accept_i = 1'b0;
    send_seq(8'h01, 4, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    repeat (3) begin
      @(negedge clk_i);
      chk("stall_ready", 64'(byte_ready_o), 64'd0);
    end
    chk("stall_idle", 64'(idle_o), 64'd0);
    @(posedge clk_i);
    #1;
    outport_accept_i = 1'b1;
    drain();

    // Reset mid-operation with a word pending.
    outport_accept_i = 1'b0;
    send_seq(8'h31, 6, 1'b0);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    outport_accept_i = 1'b1;
    send_seq(8'hA0, 4, 1'b1);
    drain();
    chk("count_after_rst", 64'(byte_count_o), 64'd4);

    // FF D9 without byte_last_i.
    send(8'h55, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hD9, 1'b0);
    send(8'h66, 1'b1);
    drain();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("count_final", 64'(byte_count_o), 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_byte_packer.md
Name: jpeg_byte_packer

Overview:
Transmit-side feeder for the decoder input port. Accepts a byte stream (valid/ready) from a file/DMA/host source and packs the bytes little-endian into 32-bit words with byte strobes and a last flag, driving the decoder's inport_valid/data/strb/last/accept interface. A partial word is flushed on the last byte. One accumulator plus a one-entry output slot let packing continue under backpressure.

Parameters:
CNT_W, 32, width of the accepted-byte counter (wraps modulo 2^CNT_W)

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  asynchronous, active-low reset
byte_valid_i  in  1  source byte valid
byte_data_i  in  8  source byte
byte_last_i  in  1  final byte of the image stream
byte_ready_o  out  1  packer accepts the byte this cycle
outport_valid_o  out  1  word valid toward the decoder inport
outport_data_o  out  32  packed word; byte k in bits [8k+7:8k]
outport_strb_o  out  4  valid-byte mask; always contiguous from bit 0
outport_last_o  out  1  word holds the final byte
outport_accept_i  in  1  decoder accepts the word (inport_accept_o)
byte_count_o  out  CNT_W  total bytes accepted since reset
idle_o  out  1  accumulator and output slot both empty

Behaviour:
- Reset (rst_i=0, async): outport_valid_o=0, outport_data_o=0, outport_strb_o=0, outport_last_o=0, byte_count_o=0, idle_o=1. Accumulator count acc_cnt_q=0, acc_last_q=0.
- Byte handshake: byte fires when byte_valid_i & byte_ready_o.
- Word handshake: word fires when outport_valid_o & outport_accept_i. Output fields hold stable while valid and not accepted.
- slot_free = ~outport_valid_o | outport_accept_i.
- byte_ready_o = ~acc_last_q & (slot_free | acc_cnt_q<3). It must not depend combinationally on byte_valid_i or byte_data_i.
- Fired byte is written to lane acc_cnt_q. The word completes when acc_cnt_q==3 or the byte carries last.
- Completion with slot_free: the word moves into the output slot the same edge. First output valid is 1 cycle after the 4th byte fires. The accumulator clears: count 0, data 0.
- Completion without slot_free is possible only for a last byte with acc_cnt_q<3. The byte is stored and acc_last_q=1. The partial word is pushed on the first edge where slot_free=1, then acc_last_q clears. byte_ready_o=0 while acc_last_q=1.
- outport_strb_o = (1<<n)-1 for n bytes (n=1..4). Unused lanes are zero. outport_last_o is set only on the word containing the last byte.
- No zero-byte words are ever emitted.
- byte_count_o increments by 1 per fired byte and wraps.
- idle_o = (acc_cnt_q==0) & ~acc_last_q & ~outport_valid_o.
- Reset mid-operation discards the accumulator and output slot with no partial flush. The first byte after reset goes to lane 0.
- Back-to-back last words are allowed: a new stream may start on the cycle after the last byte fires. Its first word queues behind a still-pending last word.

Optional Feature:
JPEG_PACKER_EOI_DETECT_EN
- With the macro: a registered flag marks that the previous fired byte was 0xFF. A fired 0xD9 with the flag set is treated exactly as if byte_last_i=1 (forced flush, last=1). The flag clears on reset and after any last.
- Without the macro: last is driven solely by byte_last_i. No extra flops.

Decomposition:
- Package jpeg_packer_pkg: BYTES_PER_WORD=4, JPEG_MARKER_PREFIX=8'hFF, JPEG_EOI=8'hD9, function strb_from_count(n) returning the 4-bit mask.
- One sub-module, jpeg_packer_out_slot: one-entry valid/accept holding register for {data, strb, last}. It exports slot_free.
- Accumulator, ready logic, counter and EOI detect stay in the top module.

Test Plan:
- 8 bytes 01..08, last on 08, accept held 1 -> words 0x04030201 strb F last 0, then 0x08070605 strb F last 1. byte_count_o=8, idle_o=1 afterwards.
- 5 bytes 11..15, last on 15 -> 0x14131211 strb F, then 0x00000015 strb 1 last 1. 1-, 2- and 3-byte tails give strb 1/3/7.
- accept held 0 for 10 cycles, 9 bytes offered -> one word held stable and 3 more bytes buffered. byte_ready_o drops when the 4th byte is pending. No data loss or reordering after accept rises.
- Last byte arrives at acc_cnt 1 with the slot stalled -> byte_ready_o=0 until the slot drains. Partial word 0x0000BBAA strb 3 last 1 is emitted next.
- rst_i pulsed low after 6 bytes with a word pending -> all outputs return to reset values immediately. The next stream 0xA0..0xA3 emits 0xA3A2A1A0 with no stale lanes.
- EOI (macro defined): FF D9 sent with byte_last_i=0 -> word ending in D9 has last 1. With the macro undefined, last stays 0.
